// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// with a saturating starvation counter that forces a fetch grant under data pressure.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_grant_if;
    logic           w_grant_d;
    logic           w_complete;
    logic           w_ack_any;
    logic           r_owner;        // 0 = fetch, 1 = data
    logic [CW-1:0]  r_starve_cnt;
    logic           r_mem_valid;
    logic           r_mem_we;
    logic [31:0]    r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic [3:0]     r_mem_wstrb;
    logic           r_busy;

    // Per-requester completion: index 0 is fetch, index 1 is data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic        r_ack;
            logic [31:0] r_rdata;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ack   <= 1'b0;
                    r_rdata <= 32'd0;
                end else begin
                    r_ack <= w_complete && (r_owner == 1'(gi));
                    if (w_complete && (r_owner == 1'(gi))) begin
                        r_rdata <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign w_ack_any = g_port[0].r_ack | g_port[1].r_ack;

    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                // The ack cycle is skipped so a held req counts as a fresh request.
                if (!w_ack_any) begin
                    if (d_req && !(if_req && (r_starve_cnt == LIMIT))) begin
                        w_grant_d = 1'b1;
                    end else if (if_req) begin
                        w_grant_if = 1'b1;
                    end
                    if (d_req || if_req) begin
                        w_state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_complete   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_wstrb  <= 4'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mem_valid <= (w_state_next == ISSUE);
            r_busy      <= (w_state_next != IDLE);
            if (w_grant_d) begin
                r_owner     <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_mem_wstrb <= d_we ? d_wstrb : 4'd0;
                if (!if_req) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (w_grant_if) begin
                r_owner      <= 1'b0;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= if_addr;
                r_mem_wdata  <= 32'd0;
                r_mem_wstrb  <= 4'd0;
                r_starve_cnt <= '0;
            end
        end
    end

    assign if_ack    = g_port[0].r_ack;
    assign if_rdata  = g_port[0].r_rdata;
    assign d_ack     = g_port[1].r_ack;
    assign d_rdata   = g_port[1].r_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and memory against a transaction-level
// model, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus controls ----------------
    bit          auto_if = 0, auto_d = 0;
    bit          keep_if = 0, keep_d = 0, rand_keep = 0;
    bit          rand_mem = 0, glitch = 0, fixed_rd = 0;
    int          rdy_dly = 0, rv_dly = 0;
    logic [31:0] rd_val = 32'd0;

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom();
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom();
        d_wdata = $urandom();
        d_wstrb = 4'($urandom_range(0, 15));
    endtask

    task automatic give_rv();
        mem_rvalid = 1'b1;
        mem_rdata  = fixed_rd ? rd_val : $urandom();
    endtask

    // Memory responder and requester agents, acting 1 time unit after each edge.
    initial begin
        int ph;
        int cnt;
        ph  = 0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom();
            if (ph == 0 && mem_valid) begin
                ph  = 1;
                cnt = 0;
                if (rand_mem) begin
                    rdy_dly = $urandom_range(0, 3);
                    rv_dly  = $urandom_range(0, 3);
                end
            end
            if (ph == 1) begin
                if (cnt == rdy_dly) begin
                    mem_ready = 1'b1;
                    if (rv_dly == 0) begin
                        give_rv();
                        ph = 0;
                    end else begin
                        ph  = 2;
                        cnt = 0;
                    end
                end else begin
                    cnt++;
                    if (glitch && $urandom_range(0, 4) == 0) give_rv();
                end
            end else if (ph == 2) begin
                cnt++;
                if (cnt == rv_dly) begin
                    give_rv();
                    ph = 0;
                end
            end else if (glitch && $urandom_range(0, 9) == 0) begin
                give_rv();
            end

            if (if_ack) begin
                if (keep_if || (rand_keep && $urandom_range(0, 1) == 1)) new_if();
                else if_req = 1'b0;
            end else if (auto_if && !if_req && $urandom_range(0, 99) < 30) begin
                new_if();
            end
            if (d_ack) begin
                if (keep_d || (rand_keep && $urandom_range(0, 1) == 1)) new_d();
                else d_req = 1'b0;
            end else if (auto_d && !d_req && $urandom_range(0, 99) < 40) begin
                new_d();
            end
        end
    end

    // ---------------- reference model ----------------
    bit          m_started = 0;
    bit          m_active = 0, m_acc = 0, m_own_d = 0;
    int          m_starve = 0;
    logic        e_rst = 1'b0;
    logic        e_if_ack = 1'b0, e_d_ack = 1'b0, e_mem_valid = 1'b0, e_busy = 1'b0;
    logic        e_we = 1'b0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_if_rdata = 32'd0, e_d_rdata = 32'd0;
    logic [3:0]  e_wstrb = 4'd0;

    always @(posedge clk) begin
        bit done;
        done      = 0;
        m_started = 1;
        if (rst) begin
            m_active = 0; m_acc = 0; m_own_d = 0; m_starve = 0;
            e_rst = 1'b1; e_if_ack = 1'b0; e_d_ack = 1'b0; e_mem_valid = 1'b0; e_busy = 1'b0;
            e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_wstrb = 4'd0;
            e_if_rdata = 32'd0; e_d_rdata = 32'd0;
        end else begin
            e_rst = 1'b0;
            if (!m_active) begin
                if (!e_if_ack && !e_d_ack) begin
                    if (d_req && !(if_req && m_starve == SL)) begin
                        m_active = 1; m_acc = 0; m_own_d = 1;
                        e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
                        e_wstrb = d_we ? d_wstrb : 4'd0;
                        m_starve = if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                    end else if (if_req) begin
                        m_active = 1; m_acc = 0; m_own_d = 0;
                        e_we = 1'b0; e_addr = if_addr; e_wstrb = 4'd0;
                        m_starve = 0;
                    end
                end
            end else if (!m_acc) begin
                if (mem_ready) begin
                    if (mem_rvalid) done = 1;
                    else m_acc = 1;
                end
            end else if (mem_rvalid) begin
                done = 1;
            end
            e_if_ack = 1'b0;
            e_d_ack  = 1'b0;
            if (done) begin
                m_active = 0;
                if (m_own_d) begin e_d_ack = 1'b1; e_d_rdata = mem_rdata; end
                else begin e_if_ack = 1'b1; e_if_rdata = mem_rdata; end
            end
            e_mem_valid = m_active && !m_acc;
            e_busy      = m_active;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_started) begin
            chk("mem_valid", mem_valid, e_mem_valid);
            chk("busy", busy, e_busy);
            chk("if_ack", if_ack, e_if_ack);
            chk("d_ack", d_ack, e_d_ack);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("ack_excl", if_ack & d_ack, 1'b0);
            if (e_mem_valid || e_rst) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", mem_wstrb, e_wstrb);
            end
            if ((e_mem_valid && m_own_d) || e_rst) chk("mem_wdata", mem_wdata, e_wdata);
            if (if_ack) $display("txn fetch: rdata=%h t=%0t", if_rdata, $time);
            if (d_ack)  $display("txn data: rdata=%h t=%0t", d_rdata, $time);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            cyc(1);
            if (!busy && !if_req && !d_req && !if_ack && !d_ack) ok = 1;
        end
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy, expected idle within 300 cycles");
        end
    endtask

    initial begin
        string s;
        bit    seen;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        cyc(3);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cyc(2);

        // Single fetch: ready in cycle 1, rvalid in cycle 2, ack in cycle 3.
        rdy_dly = 0; rv_dly = 1; fixed_rd = 1; rd_val = 32'h0010_0073;
        if_addr = 32'h8000_0000; if_req = 1'b1;
        cyc(1);
        chk("f_mem_valid", mem_valid, 1'b1);
        chk("f_mem_addr", mem_addr, 32'h8000_0000);
        chk("f_mem_we", mem_we, 1'b0);
        cyc(1);
        chk("f_wait_busy", busy, 1'b1);
        cyc(1);
        chk("f_if_ack", if_ack, 1'b1);
        chk("f_if_rdata", if_rdata, 32'h0010_0073);
        cyc(1);
        chk("f_busy_after", busy, 1'b0);
        chk("f_ack_once", if_ack, 1'b0);
        wait_idle();

        // Store with ready delayed 3 cycles: request held for 4 cycles.
        rdy_dly = 3; rv_dly = 1;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3; d_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("s_valid", mem_valid, 1'b1);
            chk("s_addr", mem_addr, 32'h100);
            chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("s_wstrb", mem_wstrb, 4'h3);
            chk("s_we", mem_we, 1'b1);
        end
        cyc(1);
        chk("s_valid_drop", mem_valid, 1'b0);
        chk("s_no_ack_yet", d_ack, 1'b0);
        cyc(1);
        chk("s_d_ack", d_ack, 1'b1);
        chk("s_if_ack", if_ack, 1'b0);
        wait_idle();

        // Both requesters held and re-raised: fetch wins every fifth grant.
        rdy_dly = 0; rv_dly = 0;
        keep_if = 1; keep_d = 1;
        if_addr = 32'h4000; if_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h500; d_req = 1'b1;
        s = "";
        for (int i = 0; i < 200 && s.len() < 10; i++) begin
            cyc(1);
            if (d_ack)  s = {s, "D"};
            if (if_ack) s = {s, "F"};
        end
        keep_if = 0; keep_d = 0;
        n_vec++;
        if (s != "DDDDFDDDDF") begin
            n_fail++;
            $display("FAIL starve_order: got %s, expected DDDDFDDDDF", s);
        end
        wait_idle();

        // Ready and rvalid in the same ISSUE cycle: ack next cycle, no WAIT.
        rd_val = 32'hCAFE_0001;
        d_we = 1'b0; d_addr = 32'h600; d_req = 1'b1;
        cyc(1);
        chk("z_valid", mem_valid, 1'b1);
        chk("z_wstrb_load", mem_wstrb, 4'h0);
        cyc(1);
        chk("z_d_ack", d_ack, 1'b1);
        chk("z_d_rdata", d_rdata, 32'hCAFE_0001);
        chk("z_busy", busy, 1'b0);
        wait_idle();

        // Fetch alone after a data grant made with if_req low.
        if_addr = 32'h3000; if_req = 1'b1;
        cyc(1);
        chk("fa_valid", mem_valid, 1'b1);
        chk("fa_addr", mem_addr, 32'h3000);
        chk("fa_wstrb", mem_wstrb, 4'h0);
        wait_idle();

        // Reset in WAIT; the late rvalid must be ignored.
        rdy_dly = 0; rv_dly = 3; rd_val = 32'h1234_5678;
        d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
        cyc(2);
        chk("r_in_wait", busy, 1'b1);
        rst = 1'b1;
        cyc(1);
        chk("r_valid", mem_valid, 1'b0);
        chk("r_busy", busy, 1'b0);
        chk("r_if_rdata", if_rdata, 32'd0);
        chk("r_d_rdata", d_rdata, 32'd0);
        chk("r_addr", mem_addr, 32'd0);
        rst = 1'b0;
        cyc(1);
        chk("r_late_rvalid_seen", mem_rvalid, 1'b1);
        chk("r_no_ack", d_ack, 1'b0);
        cyc(1);
        chk("r_regrant", mem_valid, 1'b1);
        chk("r_regrant_addr", mem_addr, 32'h200);
        chk("r_no_ack2", d_ack, 1'b0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cyc(1);
            if (d_ack) seen = 1;
        end
        chk("r_final_ack", seen, 1'b1);
        chk("r_final_rdata", d_rdata, 32'h1234_5678);
        wait_idle();

        // Randomised traffic with random memory latency and stray rvalids.
        fixed_rd = 0; rand_mem = 1; glitch = 1; rand_keep = 1;
        auto_if = 1; auto_d = 1;
        cyc(3000);
        auto_if = 0; auto_d = 0; rand_keep = 0;
        wait_idle();
        glitch = 0;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer that shares one single-port unified memory between the core's instruction-fetch path and its load/store path. It serialises requests onto a valid/ready + response handshake toward the memory, returns read data and a one-cycle acknowledge to the winning requester, and prevents fetch starvation under sustained data traffic. It sits between the processor core's fetch/LSU ports and the memory model.

## Interface
Parameters:
- STARVE_LIMIT, 4, number of consecutive data grants made while a fetch is pending before fetch is forced to win; legal range ≥ 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  32  fetch address.
- if_ack  out  1  one-cycle completion pulse; if_rdata valid in the same cycle.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata/d_wstrb stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables.
- d_ack  out  1  one-cycle completion pulse; d_rdata valid in the same cycle (loads).
- d_rdata  out  32  load data.
- mem_valid  out  1  request to memory.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/32/32/4  request fields; stable while mem_valid is high.
- mem_ready  in  1  memory accepts the request when mem_valid && mem_ready.
- mem_rvalid  in  1  completion for the accepted request (reads and writes).
- mem_rdata  in  32  read data, valid with mem_rvalid.
- busy  out  1  high in ISSUE or WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT. One transaction is outstanding at most.
- IDLE: sample requests. If neither is pending, stay. If one is pending, grant it. If both are pending, grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch. Latch the owner and request fields into the mem_* registers, then go to ISSUE.
- ISSUE: mem_valid = 1. Stay until mem_ready. On mem_ready, go to WAIT. If mem_rvalid is also high in the same cycle, complete directly.
- WAIT: mem_valid = 0. Stay until mem_rvalid.
- Completion: on mem_rvalid (in WAIT, or in ISSUE together with mem_ready):
  - register mem_rdata into the owner's rdata;
  - pulse the owner's ack in the next cycle;
  - return to IDLE.
- IDLE does not sample requests in the cycle that ack is high. The next grant is evaluated one cycle after ack, so a requester that keeps req high after its ack is treated as presenting a new request.
- Fetch requests are forced to mem_we = 0 and mem_wstrb = 0. Data loads drive mem_wstrb = 0.
- starve_cnt, width $clog2(STARVE_LIMIT+1), updated at each grant:
  - data grant with if_req high: increment, saturating at STARVE_LIMIT;
  - data grant with if_req low: clear to 0;
  - any fetch grant: clear to 0.
- mem_rvalid in IDLE, or in ISSUE without mem_ready, is a protocol error. It is ignored and causes no ack.
- if_rdata/d_rdata hold their last value until overwritten by a completion for the same requester.
- Reset (including mid-transaction):
  - state → IDLE; starve_cnt → 0;
  - all outputs → 0: mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack, if_rdata, d_rdata, busy;
  - a late mem_rvalid for the aborted transaction arrives in IDLE and is ignored.

## Timing
- Best-case latency: req sampled in cycle 0 → mem_valid in cycle 1 → mem_ready and mem_rvalid in cycle 1 → ack in cycle 2.
- With mem_ready in cycle 1 and mem_rvalid in cycle k ≥ 2, ack is in cycle k+1.
- Back-to-back throughput with zero-wait memory is one transaction per 3 cycles: IDLE, ISSUE, ack/IDLE.
- All outputs are registered. No combinational path exists from any input to any output.
- Acks are exactly one cycle wide. if_ack and d_ack are never high in the same cycle.

## Test plan
- Single fetch: if_req=1, if_addr=0x80000000; memory gives ready in cycle 1 and rvalid with rdata=0x00100073 in cycle 2 → mem_addr=0x80000000, mem_we=0 in cycle 1; if_ack=1 with if_rdata=0x00100073 in cycle 3; busy low after.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0x3; memory ready is delayed 3 cycles → mem_valid and fields held stable for 4 cycles; d_ack one cycle after rvalid; if_ack stays 0.
- Simultaneous requests, STARVE_LIMIT=4, both reqs held high with each re-raised after its ack → grant order data, data, data, data, fetch, data…; starve_cnt reads 4 at the fetch grant, then 0.
- Fetch alone after a data grant made with if_req low → starve_cnt is 0 and fetch is granted next.
- ready and rvalid in the same ISSUE cycle → ack in the next cycle; WAIT is never entered.
- rst asserted in WAIT, then mem_rvalid arrives 2 cycles later → all outputs 0 during reset; no ack; the FSM in IDLE grants a new pending request normally.
